aes_128_sched: RTL and testbench

AES_128_SCHED -- requirements
Module: aes_128_sched

---
 rtl/aes_128_sched_if.sv | 44 ++++
 rtl/aes_128_sched.sv | 151 +++++++++++++++
 tb/tb_aes_128_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_128_sched_if.sv
// Bundle of the requester, core and result signals of the AES-128 request scheduler.
// The scheduler uses the slave view; whoever drives requests and owns the core uses master.
interface aes_128_sched_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_state;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_state;
    logic [127:0] req1_key;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         res_src;
    logic         idle;

    modport slave (
        input  req0_valid, req0_state, req0_key,
        output req0_ready,
        input  req1_valid, req1_state, req1_key,
        output req1_ready,
        output core_state, core_key,
        input  core_out,
        output res_valid, res_data, res_src,
        input  res_ready,
        output idle
    );

    modport master (
        output req0_valid, req0_state, req0_key,
        input  req0_ready,
        output req1_valid, req1_state, req1_key,
        input  req1_ready,
        input  core_state, core_key,
        output core_out,
        input  res_valid, res_data, res_src,
        output res_ready,
        input  idle
    );
endinterface

// File: rtl/aes_128_sched.sv
// Two-requester front end for a fixed-latency pipelined AES-128 core.
// Requests are granted round-robin and only when a result FIFO slot is
// guaranteed; results come back in issue order through a FWFT FIFO.
module aes_128_sched #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 32
) (
    input  logic           clk,
    input  logic           rst,
    aes_128_sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + 1;

    logic [CW-1:0]    inflight_r;
    logic [CW-1:0]    fifo_count_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [128:0]     fifo_mem_r [DEPTH];
    logic [LATENCY:0] tag_valid_r;
    logic [LATENCY:0] tag_src_r;
    logic             prio_r;
    logic [127:0]     core_state_r;
    logic [127:0]     core_key_r;

    logic [SW-1:0]    occupancy_s;
    logic             credit_ok_s;
    logic             grant_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic [128:0]     head_s;

    assign occupancy_s = {1'b0, inflight_r} + {1'b0, fifo_count_r};
    assign credit_ok_s = (occupancy_s < SW'(DEPTH));
    assign empty_s     = (fifo_count_r == {CW{1'b0}});
    assign push_s      = tag_valid_r[LATENCY];
    assign pop_s       = ~empty_s & bus.res_ready;
    assign issue_s     = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
    assign head_s      = fifo_mem_r[rd_ptr_r];

    // Round-robin choice: a lone requester wins outright, a tie goes to prio_r.
    always_comb begin
        grant_s = prio_r;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = prio_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else if (bus.req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = prio_r;
        end
    end

    assign bus.req0_ready = credit_ok_s & ~grant_s;
    assign bus.req1_ready = credit_ok_s & grant_s;

    // Priority pointer flips to the requester that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (issue_s) begin
            prio_r <= ~grant_s;
        end
    end

    // Operand registers feeding the core, loaded only when a request issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state_r <= 128'd0;
            core_key_r   <= 128'd0;
        end else if (issue_s) begin
            core_state_r <= grant_s ? bus.req1_state : bus.req0_state;
            core_key_r   <= grant_s ? bus.req1_key   : bus.req0_key;
        end
    end

    assign bus.core_state = core_state_r;
    assign bus.core_key   = core_key_r;

    // Tag pipeline shadowing the core so each result is captured exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_r <= '0;
            tag_src_r   <= '0;
        end else begin
            tag_valid_r <= {tag_valid_r[LATENCY-1:0], issue_s};
            tag_src_r   <= {tag_src_r[LATENCY-1:0], grant_s};
        end
    end

    // In-flight counter: up on issue, down when the result lands in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= {CW{1'b0}};
        end else begin
            case ({issue_s, push_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Result storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {tag_src_r[LATENCY], bus.core_out};
        end
    end

    // Head of FIFO presented directly, forced to zero while empty.
    always_comb begin
        bus.res_data = 128'd0;
        bus.res_src  = 1'b0;
        if (empty_s) begin
            bus.res_data = 128'd0;
            bus.res_src  = 1'b0;
        end else begin
            bus.res_data = head_s[127:0];
            bus.res_src  = head_s[128];
        end
    end

    assign bus.res_valid = ~empty_s;
    assign bus.idle      = (inflight_r == {CW{1'b0}}) & empty_s;
endmodule

// File: tb/tb_aes_128_sched.sv
// Self-checking bench for aes_128_sched: a behavioural AES-128 core model
// drives core_out, and each test task compares the scheduler against
// round-robin / credit / ordering expectations computed here.
module tb_aes_128_sched;
    localparam int LAT = 21;
    localparam int DEP = 32;

    logic clk;
    logic rst;
    int   nchecks;
    int   nerrors;
    int   cyc;
    int   exp_next;

    logic [7:0]   sbox [256];
    logic [127:0] pipe [LAT];
    logic [127:0] last_s, last_k, last_ct;
    bit           have_cache;

    logic [128:0] res_q [$];
    int           res_cyc_q [$];

    aes_128_sched_if bus ();

    aes_128_sched #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h000000};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: samples its operands every edge, result appears LAT edges later.
    always @(posedge clk) begin
        if (!have_cache || bus.core_state !== last_s || bus.core_key !== last_k) begin
            last_s     = bus.core_state;
            last_k     = bus.core_key;
            last_ct    = aes_enc(last_s, last_k);
            have_cache = 1'b1;
        end
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= last_ct;
    end
    assign bus.core_out = pipe[LAT-1];

    // Result log: every accepted result with the cycle it was taken.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            res_q.push_back({bus.res_src, bus.res_data});
            res_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        res_q.delete();
        res_cyc_q.delete();
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_state = 128'd0;
        bus.req0_key   = 128'd0;
        bus.req1_state = 128'd0;
        bus.req1_key   = 128'd0;
        bus.res_ready  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        exp_next = 0;
        tick();
        nchecks++; if (bus.res_valid !== 1'b0) begin nerrors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        nchecks++; if (bus.res_data !== 128'd0) begin nerrors++; $display("FAIL reset_res_data got %h want 0", bus.res_data); end
        nchecks++; if (bus.res_src !== 1'b0) begin nerrors++; $display("FAIL reset_res_src got %b want 0", bus.res_src); end
        nchecks++; if (bus.idle !== 1'b1) begin nerrors++; $display("FAIL reset_idle got %b want 1", bus.idle); end
        nchecks++; if (bus.core_state !== 128'd0 || bus.core_key !== 128'd0) begin nerrors++; $display("FAIL reset_core_ops got %h/%h want 0/0", bus.core_state, bus.core_key); end
        bus.req0_valid = 1'b1;
        #1;
        nchecks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin nerrors++; $display("FAIL reset_ready_only0 got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req1_valid = 1'b1;
        #1;
        nchecks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin nerrors++; $display("FAIL reset_ready_both got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 1'b0;
        #1;
        nchecks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin nerrors++; $display("FAIL reset_ready_only1 got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_kat();
        clear_logs();
        bus.req0_state = 128'h3243f6a8885a308d313198a2e0370734;
        bus.req0_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus.req0_valid = 1'b1;
        bus.res_ready  = 1'b1;
        @(negedge clk);
        nchecks++; if (bus.req0_ready !== 1'b1) begin nerrors++; $display("FAIL kat_ready got %b want 1", bus.req0_ready); end
        tick();                        // edge T
        bus.req0_valid = 1'b0;
        exp_next = 1;
        repeat (LAT) tick();           // after T+21
        nchecks++; if (bus.res_valid !== 1'b0 || bus.idle !== 1'b0) begin nerrors++; $display("FAIL kat_early got valid=%b idle=%b want 0/0", bus.res_valid, bus.idle); end
        tick();                        // after T+22
        nchecks++; if (bus.res_valid !== 1'b1) begin nerrors++; $display("FAIL kat_valid got %b want 1", bus.res_valid); end
        nchecks++; if (bus.res_data !== 128'h3925841d02dc09fbdc118597196a0b32) begin nerrors++; $display("FAIL kat_data got %h want 3925841d02dc09fbdc118597196a0b32", bus.res_data); end
        nchecks++; if (bus.res_src !== 1'b0) begin nerrors++; $display("FAIL kat_src got %b want 0", bus.res_src); end
        tick();
        nchecks++; if (bus.res_valid !== 1'b0 || bus.idle !== 1'b1) begin nerrors++; $display("FAIL kat_drain got valid=%b idle=%b want 0/1", bus.res_valid, bus.idle); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [3];
        logic [127:0] ky [3];
        logic [127:0] exp_d;
        int           n;
        st[0] = 128'd0; ky[0] = 128'd0;
        st[1] = 128'd0; ky[1] = 128'd1;
        st[2] = 128'd1; ky[2] = 128'd0;
        clear_logs();
        bus.res_ready  = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req1_state = st[i];
            bus.req1_key   = ky[i];
            @(negedge clk);
            nchecks++; if (bus.req1_ready !== 1'b1) begin nerrors++; $display("FAIL b2b_ready%0d got %b want 1", i, bus.req1_ready); end
            tick();
        end
        bus.req1_valid = 1'b0;
        exp_next = 0;
        n = 0;
        while (!bus.idle && n < 100) begin tick(); n++; end
        nchecks++; if (n >= 100) begin nerrors++; $display("FAIL b2b_timeout got %0d cycles want <100", n); end
        nchecks++; if (res_q.size() != 3) begin nerrors++; $display("FAIL b2b_count got %0d want 3", res_q.size()); end
        nchecks++; if (res_q.size() > 0 && res_q[0][127:0] !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin nerrors++; $display("FAIL b2b_zero_vector got %h want 66e94bd4ef8a2c3b884cfa59ca342b2e", res_q[0][127:0]); end
        for (int i = 0; i < 3 && i < res_q.size(); i++) begin
            exp_d = aes_enc(st[i], ky[i]);
            nchecks++; if (res_q[i] !== {1'b1, exp_d}) begin nerrors++; $display("FAIL b2b_res%0d got %h want %h", i, res_q[i], {1'b1, exp_d}); end
            if (i > 0) begin
                nchecks++; if (res_cyc_q[i] != res_cyc_q[i-1] + 1) begin nerrors++; $display("FAIL b2b_gap%0d got %0d want %0d", i, res_cyc_q[i], res_cyc_q[i-1] + 1); end
            end
        end
    endtask

    task automatic test_alternate();
        logic [128:0] exp_q [$];
        logic         r0, r1;
        int           n;
        clear_logs();
        bus.res_ready  = 1'b1;
        bus.req0_state = rand128(); bus.req0_key = rand128();
        bus.req1_state = rand128(); bus.req1_key = rand128();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            nchecks++; if ({r0, r1} !== ((exp_next == 0) ? 2'b10 : 2'b01)) begin nerrors++; $display("FAIL alt_grant%0d got %b want next=%0d", c, {r0, r1}, exp_next); end
            if (exp_next == 0) exp_q.push_back({1'b0, aes_enc(bus.req0_state, bus.req0_key)});
            else               exp_q.push_back({1'b1, aes_enc(bus.req1_state, bus.req1_key)});
            tick();
            if (exp_next == 0) begin bus.req0_state = rand128(); bus.req0_key = rand128(); end
            else               begin bus.req1_state = rand128(); bus.req1_key = rand128(); end
            exp_next = 1 - exp_next;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.idle && n < 200) begin tick(); n++; end
        nchecks++; if (n >= 200) begin nerrors++; $display("FAIL alt_timeout got %0d cycles want <200", n); end
        nchecks++; if (res_q.size() != exp_q.size()) begin nerrors++; $display("FAIL alt_count got %0d want %0d", res_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
            nchecks++; if (res_q[i] !== exp_q[i]) begin nerrors++; $display("FAIL alt_res%0d got %h want %h", i, res_q[i], exp_q[i]); end
            if (i > 0) begin
                nchecks++; if (res_cyc_q[i] != res_cyc_q[i-1] + 1) begin nerrors++; $display("FAIL alt_bubble%0d got %0d want %0d", i, res_cyc_q[i], res_cyc_q[i-1] + 1); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [128:0] exp_q [$];
        logic         r0, r1;
        int           issued, resumed, n;
        clear_logs();
        issued = 0;
        resumed = 0;
        bus.res_ready  = 1'b0;
        bus.req0_state = rand128(); bus.req0_key = rand128();
        bus.req1_state = rand128(); bus.req1_key = rand128();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            if (issued < DEP) begin
                nchecks++; if ({r0, r1} !== ((exp_next == 0) ? 2'b10 : 2'b01)) begin nerrors++; $display("FAIL bp_grant%0d got %b want next=%0d", c, {r0, r1}, exp_next); end
            end else begin
                nchecks++; if ({r0, r1} !== 2'b00) begin nerrors++; $display("FAIL bp_full%0d got %b want 00", c, {r0, r1}); end
            end
            if (r0) exp_q.push_back({1'b0, aes_enc(bus.req0_state, bus.req0_key)});
            if (r1) exp_q.push_back({1'b1, aes_enc(bus.req1_state, bus.req1_key)});
            tick();
            if (r0) begin bus.req0_state = rand128(); bus.req0_key = rand128(); end
            if (r1) begin bus.req1_state = rand128(); bus.req1_key = rand128(); end
            if (issued < DEP) begin issued++; exp_next = 1 - exp_next; end
        end
        nchecks++; if (exp_q.size() != DEP) begin nerrors++; $display("FAIL bp_accepted got %0d want %0d", exp_q.size(), DEP); end
        bus.res_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            if (r0 || r1) begin
                nchecks++; if ({r0, r1} !== ((exp_next == 0) ? 2'b10 : 2'b01)) begin nerrors++; $display("FAIL bp_resume_grant%0d got %b want next=%0d", c, {r0, r1}, exp_next); end
                if (r0) exp_q.push_back({1'b0, aes_enc(bus.req0_state, bus.req0_key)});
                if (r1) exp_q.push_back({1'b1, aes_enc(bus.req1_state, bus.req1_key)});
                exp_next = 1 - exp_next;
                resumed++;
            end
            tick();
            if (r0) begin bus.req0_state = rand128(); bus.req0_key = rand128(); end
            if (r1) begin bus.req1_state = rand128(); bus.req1_key = rand128(); end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.idle && n < 300) begin tick(); n++; end
        nchecks++; if (n >= 300) begin nerrors++; $display("FAIL bp_timeout got %0d cycles want <300", n); end
        nchecks++; if (resumed == 0) begin nerrors++; $display("FAIL bp_resume got %0d issues want >0", resumed); end
        nchecks++; if (res_q.size() != exp_q.size()) begin nerrors++; $display("FAIL bp_count got %0d want %0d", res_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
            nchecks++; if (res_q[i] !== exp_q[i]) begin nerrors++; $display("FAIL bp_res%0d got %h want %h", i, res_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_logs();
        bus.res_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req0_state = rand128();
            bus.req0_key   = rand128();
            tick();
        end
        bus.req0_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_next = 0;
        nchecks++; if (bus.idle !== 1'b1) begin nerrors++; $display("FAIL rstmid_idle got %b want 1", bus.idle); end
        nchecks++; if (bus.core_state !== 128'd0) begin nerrors++; $display("FAIL rstmid_core got %h want 0", bus.core_state); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) seen++;
        end
        nchecks++; if (seen != 0) begin nerrors++; $display("FAIL rstmid_stale got %0d valid cycles want 0", seen); end
        nchecks++; if (res_q.size() != 0) begin nerrors++; $display("FAIL rstmid_results got %0d want 0", res_q.size()); end
    endtask

    task automatic test_fifo_count1();
        logic [127:0] sa, ka, sb, kb, ea, eb;
        clear_logs();
        sa = rand128(); ka = rand128(); sb = rand128(); kb = rand128();
        ea = aes_enc(sa, ka);
        eb = aes_enc(sb, kb);
        bus.res_ready  = 1'b0;
        bus.req0_state = sa; bus.req0_key = ka;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        nchecks++; if (bus.req0_ready !== 1'b1) begin nerrors++; $display("FAIL c1_readyA got %b want 1", bus.req0_ready); end
        tick();                        // edge T
        bus.req0_state = sb; bus.req0_key = kb;
        @(negedge clk);
        nchecks++; if (bus.req0_ready !== 1'b1) begin nerrors++; $display("FAIL c1_readyB got %b want 1", bus.req0_ready); end
        tick();                        // edge T+1
        bus.req0_valid = 1'b0;
        repeat (LAT) tick();           // after T+22
        nchecks++; if (bus.res_valid !== 1'b1 || bus.res_data !== ea) begin nerrors++; $display("FAIL c1_headA got %b/%h want 1/%h", bus.res_valid, bus.res_data, ea); end
        bus.res_ready = 1'b1;
        tick();                        // push B and pop A together
        bus.res_ready = 1'b0;
        nchecks++; if (bus.res_valid !== 1'b1 || bus.res_data !== eb) begin nerrors++; $display("FAIL c1_headB got %b/%h want 1/%h", bus.res_valid, bus.res_data, eb); end
        tick();
        nchecks++; if (bus.res_valid !== 1'b1 || bus.res_data !== eb || bus.idle !== 1'b0) begin nerrors++; $display("FAIL c1_hold got %b/%h idle=%b want 1/%h idle=0", bus.res_valid, bus.res_data, bus.idle, eb); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        nchecks++; if (bus.res_valid !== 1'b0 || bus.idle !== 1'b1) begin nerrors++; $display("FAIL c1_empty got %b idle=%b want 0 idle=1", bus.res_valid, bus.idle); end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish before limit");
        $fatal(1, "simulation timeout");
    end

    initial begin
        nchecks    = 0;
        nerrors    = 0;
        cyc        = 0;
        exp_next   = 0;
        have_cache = 1'b0;
        rst        = 1'b1;
        idle_inputs();
        test_reset();
        test_kat();
        test_back_to_back();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_fifo_count1();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
